dmem_access_controller: RTL and testbench
=========================================

Name: dmem_access_controller

Overview:
- Sequences every data-memory access issued from the EX/MEM pipeline register to an off-chip data memory that uses a req/ack handshake.
- Holds the whole pipeline with stall_o until the access completes. This includes the EX/MEM register's own stall_i.
- Returns the read data to the MEM/WB path and counts stall cycles for performance checks.

Parameters:
- ADDR_W, 32, width of data-memory address.
- DATA_W, 32, width of data word.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  pipeline run enable; when low, no access is started.
- MemRead_i  input  1  load request from the EX/MEM register.
- MemWrite_i  input  1  store request from the EX/MEM register.
- addr_i  input  ADDR_W  access address (EX/MEM ALU result).
- wdata_i  input  DATA_W  store data (EX/MEM MemWrite data).
- mem_req_o  output  1  request to the memory; held high until ack.
- mem_we_o  output  1  1 = write, 0 = read; stable while mem_req_o is high.
- mem_addr_o  output  ADDR_W  latched address.
- mem_wdata_o  output  DATA_W  latched store data.
- mem_ack_i  input  1  one-cycle completion pulse from the memory.
- mem_rdata_i  input  DATA_W  read data, valid in the mem_ack_i cycle.
- stall_o  output  1  stall to all pipeline registers and the PC.
- rdata_o  output  DATA_W  registered load result for MEM/WB.
- stall_cnt_o  output  CNT_W  total stall cycles since reset, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state goes to IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, stall_cnt_o=0.
  - stall_o=0 for as long as rst_i is low.
  - A reset during BUSY drops mem_req_o immediately; the late ack is ignored after reset.
- Definition: access = start_i & (MemRead_i | MemWrite_i).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access: latch addr_i→mem_addr_o and wdata_i→mem_wdata_o.
  - mem_we_o <= MemWrite_i; write wins if both MemRead_i and MemWrite_i are high.
  - mem_req_o <= 1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_req_o=1 and the latched outputs are held constant.
  - On mem_ack_i: mem_req_o <= 0; if a read, rdata_o <= mem_rdata_i; go to DONE.
  - Without ack, stay in BUSY indefinitely; there is no timeout.
- DONE:
  - Lasts exactly one cycle, then unconditionally IDLE.
  - The pipeline advances at the end of this cycle.
  - The same EX/MEM op is still visible on the inputs and must NOT retrigger an access.
- stall_o (combinational): 1 when (state==IDLE & access) or state==BUSY; 0 in DONE.
- Stall latency:
  - The access cycle itself stalls.
  - Minimum stall is 2 cycles: the IDLE detect cycle plus one BUSY cycle if ack arrives in the first BUSY cycle.
  - An ack N cycles after entry to BUSY (N≥0) gives N+2 stall cycles.
- Back-to-back accesses: after DONE→IDLE, a new access in the following cycle starts a new transaction.
  - There is never more than one outstanding request.
- rdata_o: unchanged by writes and by idle cycles; holds the last load value.
- stall_cnt_o: +1 every cycle stall_o=1; saturates at 2^CNT_W−1 and never wraps.
- mem_ack_i in IDLE or DONE: ignored; no state change, no rdata_o update.
- start_i low during BUSY: the transaction still completes. start_i only gates new accesses.

Test Plan:
- Reset then idle: rst_i low 3 cycles, release, MemRead_i=MemWrite_i=0 → all outputs 0, stall_o=0, stall_cnt_o=0.
- Load with ack in first BUSY cycle:
  - Stimulus: MemRead_i=1, addr_i=0x0000_0040, mem_rdata_i=0xDEAD_BEEF.
  - Response: mem_req_o=1 for 1 cycle, mem_we_o=0, mem_addr_o=0x40; stall_o high exactly 2 cycles; rdata_o=0xDEADBEEF in DONE; stall_cnt_o=2.
- Store with 5-cycle memory latency:
  - Stimulus: MemWrite_i=1, addr_i=0x80, wdata_i=0x1234_5678, ack 5 cycles after BUSY entry.
  - Response: mem_we_o=1, mem_wdata_o=0x12345678 stable throughout; stall_o high 7 cycles; rdata_o unchanged; no retrigger in DONE.
- Both read and write high: MemRead_i=MemWrite_i=1 → mem_we_o=1 (write wins); stray ack pulsed in IDLE beforehand causes no state change.
- Reset mid-BUSY: assert rst_i low asynchronously 2 cycles into BUSY → mem_req_o and stall_o drop without a clock edge; ack after release ignored; state IDLE.
- Counter saturation with CNT_W=4: hold memory with no ack for 20 cycles → stall_cnt_o stops at 15.

Source files
------------

// File: rtl/dmem_access_controller.sv
// Data-memory access sequencer: issues one req/ack transaction per EX/MEM load/store,
// stalls the pipeline until it completes, and counts stall cycles (saturating).
module dmem_access_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   access;

  assign access = start_i & (MemRead_i | MemWrite_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access) state_nxt = BUSY;
      BUSY:    if (mem_ack_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst_i so the pipeline is released for the whole reset window,
  // even while an access is presented on the inputs.
  assign stall_o = rst_i & (((state == IDLE) & access) | (state == BUSY));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= MemWrite_i;
          mem_addr_o  <= addr_i;
          mem_wdata_o <= wdata_i;
        end
        BUSY: if (mem_ack_i) begin
          mem_req_o <= 1'b0;
          if (!mem_we_o) rdata_o <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          stall_cnt_o <= '0;
    else if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Self-checking bench for dmem_access_controller: directed scenarios plus randomized
// transactions checked against a transaction-level model (N+2 stalls, last-load data).
module tb_dmem_access_controller;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              MemRead_i = 1'b0;
  logic              MemWrite_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              stall_o;
  logic [DATA_W-1:0] rdata_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: total stall cycles since reset and last load value.
  int unsigned       total_stalls = 0;
  logic [DATA_W-1:0] last_load = '0;

  dmem_access_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int unsigned sat(input int unsigned t);
    return (t > CNT_MAX) ? CNT_MAX : t;
  endfunction

  // One complete transaction starting in an IDLE cycle (called at posedge+1).
  task automatic do_access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdat,
                           input int unsigned lat, input bit drop_start);
    int unsigned stalls;
    logic [DATA_W-1:0] exp_cnt;
    stalls = 0;
    start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    @(negedge clk_i);
    if (stall_o) stalls++;
    for (int unsigned k = 0; k <= lat; k++) begin
      @(posedge clk_i); #1;
      if (drop_start) start_i = 1'b0;
      mem_ack_i   = (k == lat);
      mem_rdata_i = (k == lat) ? rdat : $urandom;
      @(negedge clk_i);
      if (stall_o) stalls++;
      vectors++;
      if (mem_req_o !== 1'b1 || mem_we_o !== wr || mem_addr_o !== a || mem_wdata_o !== wd) begin
        miscompares++;
        $display("FAIL busy_outputs k=%0d: req=%b we=%b addr=%h wdata=%h, want req=1 we=%b addr=%h wdata=%h",
                 k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wr, a, wd);
      end
    end
    if (!wr) last_load = rdat;
    total_stalls += lat + 2;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; start_i = 1'b1; mem_rdata_i = $urandom;
    @(negedge clk_i);
    if (stall_o) stalls++;
    vectors++;
    if (mem_req_o !== 1'b0 || rdata_o !== last_load) begin
      miscompares++;
      $display("FAIL done_outputs: req=%b rdata=%h, want req=0 rdata=%h", mem_req_o, rdata_o, last_load);
    end
    vectors++;
    if (stalls != lat + 2) begin
      miscompares++;
      $display("FAIL stall_length lat=%0d: got %0d cycles, want %0d", lat, stalls, lat + 2);
    end
    @(posedge clk_i); #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL no_retrigger: req=%b, want 0", mem_req_o);
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    exp_cnt = sat(total_stalls);
    vectors++;
    if (stall_cnt_o !== exp_cnt[CNT_W-1:0]) begin
      miscompares++;
      $display("FAIL stall_count: got %0d, want %0d", stall_cnt_o, exp_cnt);
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    total_stalls = 0; last_load = '0;
  endtask

  task automatic test_reset();
    start_i = 1'b1; MemRead_i = 1'b1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: stall=%b, want 0 while reset low", stall_o);
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;
    rst_i = 1'b1;
    total_stalls = 0; last_load = '0;
    @(negedge clk_i);
    vectors++;
    if ({mem_req_o, mem_we_o, stall_o} !== 3'b000 || mem_addr_o !== '0 || mem_wdata_o !== '0 ||
        rdata_o !== '0 || stall_cnt_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: req=%b we=%b stall=%b addr=%h wdata=%h rdata=%h cnt=%0d, want all 0",
               mem_req_o, mem_we_o, stall_o, mem_addr_o, mem_wdata_o, rdata_o, stall_cnt_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_first_cycle();
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_store_latency();
    do_access(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'hCAFE_F00D, 5, 1'b0);
  endtask

  task automatic test_both_and_stray_ack();
    start_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_ack_stall: stall=%b, want 0", stall_o);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== last_load) begin
      miscompares++;
      $display("FAIL stray_ack_state: req=%b stall=%b rdata=%h, want req=0 stall=0 rdata=%h",
               mem_req_o, stall_o, rdata_o, last_load);
    end
    @(posedge clk_i); #1;
    do_access(1'b1, 1'b1, 32'h0000_00C4, 32'h0BAD_F00D, 32'h1111_2222, 2, 1'b0);
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 24; i++) begin
      bit rd, wr;
      int unsigned kind;
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0);
      do_access(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        start_i = $urandom_range(0, 1);
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    start_i = 1'b1; MemRead_i = 1'b1; addr_i = 32'h100; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_drop: req=%b stall=%b, want 0 0", mem_req_o, stall_o);
    end
    total_stalls = 0; last_load = '0;
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;
    rst_i = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_8888;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== '0 || stall_cnt_o !== '0) begin
      miscompares++;
      $display("FAIL late_ack_ignored: req=%b stall=%b rdata=%h cnt=%0d, want 0 0 0 0",
               mem_req_o, stall_o, rdata_o, stall_cnt_o);
    end
    @(posedge clk_i); #1;
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h3333_4444, 1, 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    start_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h9; mem_ack_i = 1'b0;
    repeat (21) @(posedge clk_i);
    #1;
    vectors++;
    if (stall_cnt_o !== CNT_W'(CNT_MAX) || stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation: cnt=%0d stall=%b, want %0d 1", stall_cnt_o, stall_o, CNT_MAX);
    end
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    MemWrite_i = 1'b0;
    vectors++;
    if (stall_cnt_o !== CNT_W'(CNT_MAX) || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL saturation_hold: cnt=%0d req=%b, want %0d 0", stall_cnt_o, mem_req_o, CNT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_load_first_cycle();
    test_store_latency();
    test_both_and_stray_ack();
    test_random_back_to_back();
    test_reset_mid_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
